// File: rtl/mem_responder_if.sv
// Request/response bundle between a cache miss handler (master) and the memory responder (slave).
// Requests are valid-only: enable=1 issues a request at that edge, with no ready/back-pressure.
interface mem_responder_if #(
  parameter int ADDR_W = 16
);
  logic              enable;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       data_in;
  logic [15:0]       data_out;
  logic              data_valid;
  logic [3:0]        outstanding;

  modport master (
    output enable, wr, addr, data_in,
    input  data_out, data_valid, outstanding
  );

  modport slave (
    input  enable, wr, addr, data_in,
    output data_out, data_valid, outstanding
  );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency pipelined memory responder: one request per cycle, read data returned
// exactly LATENCY edges after issue, write data committed at the issue edge.
module mem_responder #(
  parameter int LATENCY = 4,
  parameter int ADDR_W  = 16,
  parameter int DEPTH_W = 15
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);

  logic [15:0]        mem [2**DEPTH_W];
  logic [LATENCY-1:0] pipe_vld;
  logic [15:0]        pipe_data [LATENCY];

  logic               issue_rd;
  logic               issue_wr;
  logic [DEPTH_W-1:0] word_idx;
  logic               unused_addr_bit;

  // Upper address bits beyond the array depth are dropped so indices alias modulo depth.
  assign word_idx        = bus.addr[DEPTH_W:1];
  assign unused_addr_bit = bus.addr[0];
  assign issue_rd        = bus.enable & ~bus.wr & ~rst;
  assign issue_wr        = bus.enable &  bus.wr & ~rst;

  always_ff @(posedge clk) begin
    if (issue_wr) begin
      mem[word_idx] <= bus.data_in;
    end
  end

  // Read data is snapshotted at issue, so later writes cannot alter an in-flight response.
  always_ff @(posedge clk) begin
    if (issue_rd) begin
      pipe_data[0] <= mem[word_idx];
    end
    for (int i = 1; i < LATENCY; i++) begin
      pipe_data[i] <= pipe_data[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld        <= '0;
      bus.data_valid  <= 1'b0;
      bus.data_out    <= 16'h0000;
      bus.outstanding <= 4'd0;
    end else begin
      pipe_vld[0] <= issue_rd;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
      end
      bus.data_valid <= pipe_vld[LATENCY-1];
      if (pipe_vld[LATENCY-1]) begin
        bus.data_out <= pipe_data[LATENCY-1];
      end
      bus.outstanding <= bus.outstanding + {3'b000, issue_rd} - {3'b000, pipe_vld[LATENCY-1]};
    end
  end

  a_ctrl_known: assert property (@(posedge clk) disable iff (rst)
    !$isunknown(bus.enable) && (!bus.enable || !$isunknown(bus.wr)));

  a_outstanding_bound: assert property (@(posedge clk) disable iff (rst)
    bus.outstanding <= 4'(LATENCY));

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a LATENCY=4 instance for ordering/reset behaviour and a
// LATENCY=1 instance for minimum latency and address aliasing.
module tb_mem_responder;

  logic clk;
  logic rst;
  int   err_cnt = 0;
  int   chk_cnt = 0;
  int   peak;
  logic [15:0] exp_q[$];

  mem_responder_if #(.ADDR_W(16)) m4 ();
  mem_responder_if #(.ADDR_W(16)) m1 ();

  mem_responder #(.LATENCY(4), .ADDR_W(16), .DEPTH_W(15)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (m4.slave)
  );

  mem_responder #(.LATENCY(1), .ADDR_W(16), .DEPTH_W(15)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (m1.slave)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks for the LATENCY=4 instance
  task automatic drv_idle();
    m4.enable  = 1'b0;
    m4.wr      = 1'b0;
    m4.addr    = 16'h0000;
    m4.data_in = 16'h0000;
    tick();
  endtask

  task automatic drv_wr(input logic [15:0] a, input logic [15:0] d);
    m4.enable  = 1'b1;
    m4.wr      = 1'b1;
    m4.addr    = a;
    m4.data_in = d;
    tick();
  endtask

  task automatic drv_rd(input logic [15:0] a, input logic [15:0] exp_d);
    exp_q.push_back(exp_d);
    m4.enable  = 1'b1;
    m4.wr      = 1'b0;
    m4.addr    = a;
    m4.data_in = 16'h0000;
    tick();
  endtask

  // driver task for the LATENCY=1 instance
  task automatic drv1(input logic en, input logic w, input logic [15:0] a, input logic [15:0] d);
    m1.enable  = en;
    m1.wr      = w;
    m1.addr    = a;
    m1.data_in = d;
    tick();
  endtask

  // scoreboard: every response of the LATENCY=4 instance must match the oldest expected read
  always @(posedge clk) begin
    if (rst) exp_q.delete();
    #1;
    if (m4.data_valid) begin
      if (exp_q.size() == 0) check("sb_spurious_valid", 32'd1, 32'd0);
      else check("sb_data", {16'h0, m4.data_out}, {16'h0, exp_q.pop_front()});
    end
  end

  initial begin
    rst = 1'b1;
    m4.enable = 1'b0; m4.wr = 1'b0; m4.addr = 16'h0; m4.data_in = 16'h0;
    m1.enable = 1'b0; m1.wr = 1'b0; m1.addr = 16'h0; m1.data_in = 16'h0;
    tick();
    tick();
    check("rst_data_out", {16'h0, m4.data_out}, 32'h0);
    check("rst_data_valid", {31'h0, m4.data_valid}, 32'h0);
    check("rst_outstanding", {28'h0, m4.outstanding}, 32'h0);
    rst = 1'b0;

    // 1: write then read, exact latency of 4
    drv_wr(16'h0010, 16'hBEEF);
    drv_rd(16'h0010, 16'hBEEF);
    check("t1_issue_valid", {31'h0, m4.data_valid}, 32'h0);
    check("t1_issue_outst", {28'h0, m4.outstanding}, 32'd1);
    for (int k = 1; k <= 3; k++) begin
      drv_idle();
      check("t1_flight_valid", {31'h0, m4.data_valid}, 32'h0);
      check("t1_flight_outst", {28'h0, m4.outstanding}, 32'd1);
    end
    drv_idle();
    check("t1_resp_valid", {31'h0, m4.data_valid}, 32'd1);
    check("t1_resp_data", {16'h0, m4.data_out}, 32'hBEEF);
    check("t1_resp_outst", {28'h0, m4.outstanding}, 32'd0);
    drv_idle();
    check("t1_after_valid", {31'h0, m4.data_valid}, 32'h0);
    check("t1_hold_data", {16'h0, m4.data_out}, 32'hBEEF);

    // 2: eight back-to-back reads
    for (int i = 0; i < 8; i++) drv_wr(16'(2 * i), 16'(16'h1000 + i));
    peak = 0;
    for (int n = 0; n < 12; n++) begin
      int issued;
      int returned;
      if (n < 8) drv_rd(16'(2 * n), 16'(16'h1000 + n));
      else drv_idle();
      issued   = (n < 8) ? n + 1 : 8;
      returned = (n >= 4) ? n - 3 : 0;
      check("t2_valid", {31'h0, m4.data_valid}, (n >= 4) ? 32'd1 : 32'd0);
      if (n >= 4) check("t2_data", {16'h0, m4.data_out}, 32'(16'h1000 + n - 4));
      check("t2_outst", {28'h0, m4.outstanding}, 32'(issued - returned));
      if (int'(m4.outstanding) > peak) peak = int'(m4.outstanding);
    end
    drv_idle();
    check("t2_tail_valid", {31'h0, m4.data_valid}, 32'h0);
    check("t2_peak_outst", 32'(peak), 32'd4);

    // 3: write after read does not disturb the in-flight snapshot
    drv_wr(16'h0020, 16'h1111);
    drv_rd(16'h0020, 16'h1111);
    drv_wr(16'h0020, 16'h2222);
    drv_idle();
    drv_idle();
    drv_idle();
    check("t3_snap_valid", {31'h0, m4.data_valid}, 32'd1);
    check("t3_snap_data", {16'h0, m4.data_out}, 32'h1111);
    drv_rd(16'h0020, 16'h2222);
    for (int k = 0; k < 3; k++) drv_idle();
    drv_idle();
    check("t3_new_valid", {31'h0, m4.data_valid}, 32'd1);
    check("t3_new_data", {16'h0, m4.data_out}, 32'h2222);

    // 4: reset discards in-flight reads but keeps the array
    drv_wr(16'h0030, 16'h5A5A);
    drv_rd(16'h0000, 16'h1000);
    drv_rd(16'h0002, 16'h1001);
    drv_rd(16'h0004, 16'h1002);
    check("t4_pre_outst", {28'h0, m4.outstanding}, 32'd3);
    drv_idle();
    rst = 1'b1;
    m4.enable = 1'b0;
    tick();
    rst = 1'b0;
    check("t4_rst_valid", {31'h0, m4.data_valid}, 32'h0);
    check("t4_rst_outst", {28'h0, m4.outstanding}, 32'h0);
    check("t4_rst_data", {16'h0, m4.data_out}, 32'h0);
    for (int k = 0; k < 6; k++) begin
      drv_idle();
      check("t4_no_valid", {31'h0, m4.data_valid}, 32'h0);
    end
    drv_rd(16'h0010, 16'hBEEF);
    for (int k = 0; k < 3; k++) drv_idle();
    drv_idle();
    check("t4_kept_valid", {31'h0, m4.data_valid}, 32'd1);
    check("t4_kept_data", {16'h0, m4.data_out}, 32'hBEEF);

    // 5: reset beats a coincident write; then read/idle/read
    rst = 1'b1;
    m4.enable = 1'b1; m4.wr = 1'b1; m4.addr = 16'h0030; m4.data_in = 16'hDEAD;
    tick();
    rst = 1'b0;
    check("t5_rst_outst", {28'h0, m4.outstanding}, 32'h0);
    drv_rd(16'h0030, 16'h5A5A);
    drv_idle();
    drv_rd(16'h0030, 16'h5A5A);
    drv_idle();
    drv_idle();
    check("t5_v0", {31'h0, m4.data_valid}, 32'd1);
    check("t5_d0", {16'h0, m4.data_out}, 32'h5A5A);
    drv_idle();
    check("t5_v1", {31'h0, m4.data_valid}, 32'd0);
    drv_idle();
    check("t5_v2", {31'h0, m4.data_valid}, 32'd1);
    check("t5_d2", {16'h0, m4.data_out}, 32'h5A5A);
    check("t5_outst", {28'h0, m4.outstanding}, 32'd0);
    drv_idle();
    check("t5_v3", {31'h0, m4.data_valid}, 32'd0);

    // 6: LATENCY=1 instance, aliasing of the top word
    drv1(1'b1, 1'b1, 16'hFFFE, 16'h7777);
    drv1(1'b1, 1'b0, 16'hFFFF, 16'h0000);
    check("t6_issue_valid", {31'h0, m1.data_valid}, 32'h0);
    check("t6_issue_outst", {28'h0, m1.outstanding}, 32'd1);
    drv1(1'b0, 1'b0, 16'h0000, 16'h0000);
    check("t6_resp_valid", {31'h0, m1.data_valid}, 32'd1);
    check("t6_resp_data", {16'h0, m1.data_out}, 32'h7777);
    check("t6_resp_outst", {28'h0, m1.outstanding}, 32'd0);
    drv1(1'b1, 1'b1, 16'h0004, 16'h4444);
    drv1(1'b1, 1'b0, 16'hFFFE, 16'h0000);
    drv1(1'b1, 1'b0, 16'h0004, 16'h0000);
    check("t6_b2b_valid0", {31'h0, m1.data_valid}, 32'd1);
    check("t6_b2b_data0", {16'h0, m1.data_out}, 32'h7777);
    check("t6_b2b_outst", {28'h0, m1.outstanding}, 32'd1);
    drv1(1'b0, 1'b0, 16'h0000, 16'h0000);
    check("t6_b2b_valid1", {31'h0, m1.data_valid}, 32'd1);
    check("t6_b2b_data1", {16'h0, m1.data_out}, 32'h4444);
    check("t6_b2b_outst1", {28'h0, m1.outstanding}, 32'd0);

    drv_idle();
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
